fp4_operand_sequencer: RTL
==========================

// Module: fp4_operand_sequencer
//
// PURPOSE
//   Upstream feeder for the FP4 MAC datapath.
//   - Accepts packed words of LANES FP4 operand pairs over a valid/ready handshake.
//   - Buffers them in a small FIFO.
//   - Serialises them into one (a,b) pair per cycle on a valid-only stream, which
//     connects directly to the MAC's i_data_valid/i_a/i_b.
//   - Marks the final pair of each vector and counts completed vectors.
//
// PARAMETERS
//   LANES   8   FP4 pairs per input word; power of 2, >=2
//   DEPTH   4   FIFO depth in words; power of 2, >=2
//   CNT_W   16  width of completed-vector counter
//
// PORTS
//   i_clk         in   1         clock, rising edge
//   i_rst_n       in   1         reset, asynchronous assert, active-low
//   i_word_valid  in   1         input word valid
//   o_word_ready  out  1         FIFO can accept a word
//   i_a_word      in   4*LANES   packed A operands, lane k = bits [4k+3:4k]
//   i_b_word      in   4*LANES   packed B operands, same packing
//   i_last        in   1         word is the final word of a vector
//   i_hold        in   1         suppress pair issue this cycle
//   o_data_valid  out  1         o_a/o_b valid (to MAC i_data_valid)
//   o_a           out  4         FP4 operand A
//   o_b           out  4         FP4 operand B
//   o_last        out  1         pair is lane LANES-1 of a word tagged i_last
//   o_busy        out  1         FIFO non-empty or pair in flight
//   o_vec_count   out  CNT_W     number of vectors fully issued, wraps
//
// BEHAVIOUR
//   Reset (i_rst_n low, async):
//   - FIFO pointers, lane index and state are cleared.
//   - Outputs go to 0: o_data_valid, o_a, o_b, o_last, o_busy, o_vec_count,
//     o_word_ready.
//   - A word or pair in flight is discarded; nothing stale is issued after release.
//   - o_word_ready rises on the first clock edge after release.
//
//   Input handshake:
//   - A push occurs when i_word_valid && o_word_ready at a rising edge.
//   - o_word_ready = !full, registered. When the FIFO is full, ready stays 0 even
//     if a pop happens the same cycle; no combinational ready-from-pop path.
//   - The FIFO stores {i_last, i_b_word, i_a_word}.
//   - Push and pop in the same cycle are allowed at any non-full occupancy; the
//     count is unchanged.
//
//   State machine:
//   - IDLE: FIFO empty, o_data_valid=0. Moves to ISSUE on the edge after the
//     first push.
//   - ISSUE: each edge with !i_hold registers the head-word lane idx onto
//     o_a/o_b and sets o_data_valid=1.
//     - Lane idx increments; lane 0 (LSBs) is issued first.
//     - On idx==LANES-1 the word is popped and idx wraps to 0.
//     - o_last = head i_last tag at idx==LANES-1; o_vec_count increments in the
//       same edge.
//     - If the FIFO is then empty, move to IDLE.
//   - i_hold=1 in ISSUE: the next cycle has o_data_valid=0. idx and the FIFO are
//     frozen; o_a/o_b keep their previous values.
//   - i_hold is ignored in IDLE.
//
//   Timing:
//   - Latency: a word pushed at edge N gives its lane-0 pair valid after edge
//     N+1 when unheld and the FIFO was empty.
//   - Throughput: one pair per cycle. Back-to-back words issue with no bubble
//     between lane LANES-1 and the next lane 0.
//
//   Counters:
//   - o_busy = (FIFO count != 0) || o_data_valid.
//   - o_vec_count wraps from 2^CNT_W-1 to 0 without a flag.
//   - Operands pass through bit-exact; no FP4 decoding is done here.
//
// TESTING
//   1. Push A=0x22222222, B=0x22222222, last=1
//      -> 8 consecutive valid cycles with o_a=o_b=0x2; o_last only on the 8th;
//         o_vec_count=1; o_busy=0 after.
//   2. A=0x76543210, B=0xFEDCBA98
//      -> o_a sequence 0..7, o_b sequence 8..F, in order.
//   3. Hold i_hold=1, push 4 words
//      -> all accepted; o_word_ready=0 afterwards and a 5th word stalls.
//      Release hold -> 32 back-to-back valid cycles; ready returns 1 the cycle
//      after the first pop.
//   4. Assert i_hold for 5 cycles after lane 3 issues
//      -> no valid for 5 cycles; next pair is lane 4 and no lane is skipped or
//         repeated.
//   5. Drop i_rst_n mid-word at lane 5 with 2 words queued
//      -> outputs 0 immediately (asynchronously); after release, no pairs issue
//         until a new push.
//   6. Occupancy 3, simultaneous push and lane-7 pop; then wrap o_vec_count
//      from 0xFFFF
//      -> occupancy stays 3; the counter reads 0x0000.

Source files
------------

// File: rtl/fp4_operand_sequencer.sv
// Buffers packed FP4 operand words in a small FIFO and serialises them into
// one (a,b) pair per cycle for the FP4 MAC, tagging vector ends and counting them.
module fp4_operand_sequencer #(
    parameter int LANES = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_word_valid,
    output logic               o_word_ready,
    input  logic [4*LANES-1:0] i_a_word,
    input  logic [4*LANES-1:0] i_b_word,
    input  logic               i_last,
    input  logic               i_hold,
    output logic               o_data_valid,
    output logic [3:0]         o_a,
    output logic [3:0]         o_b,
    output logic               o_last,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_vec_count
);

    localparam int W     = 4 * LANES;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state, state_next;

    logic [2*W:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next;
    logic [IDX_W-1:0] idx;

    logic         push, pop, issue, lane_end;
    logic [2*W:0] head;
    logic [W-1:0] head_a, head_b;
    logic         head_last;

    assign head      = mem[rd_ptr];
    assign head_a    = head[W-1:0];
    assign head_b    = head[2*W-1:W];
    assign head_last = head[2*W];
    assign o_busy    = (count != '0) || o_data_valid;

    // ISSUE is only ever occupied with a non-empty FIFO, so the head word is always real there
    always_comb begin
        push       = i_word_valid && o_word_ready;
        issue      = (state == ISSUE) && !i_hold;
        lane_end   = (idx == IDX_W'(LANES - 1));
        pop        = issue && lane_end;
        count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        state_next = state;
        case (state)
            IDLE:    if (push) state_next = ISSUE;
            ISSUE:   if (pop && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_last, i_b_word, i_a_word};
    end

    // Ready is computed from the post-edge occupancy, so it never depends on this cycle's pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            idx          <= '0;
            o_word_ready <= 1'b0;
            o_data_valid <= 1'b0;
            o_a          <= '0;
            o_b          <= '0;
            o_last       <= 1'b0;
            o_vec_count  <= '0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            o_word_ready <= (count_next != (PTR_W+1)'(DEPTH));
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (issue) begin
                o_data_valid <= 1'b1;
                o_a          <= head_a[{idx, 2'b00} +: 4];
                o_b          <= head_b[{idx, 2'b00} +: 4];
                o_last       <= lane_end && head_last;
                if (lane_end) begin
                    idx    <= '0;
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    if (head_last) o_vec_count <= o_vec_count + CNT_W'(1);
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                o_data_valid <= 1'b0;
                o_last       <= 1'b0;
            end
        end
    end

endmodule
